// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the fetch PC and pushes {pc, word} into a 2-entry skid buffer toward decode.
// A word addressed in cycle N reaches the head in N+1; fetch stalls while the buffer is full and not being popped.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 80
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  output logic [31:0] ins_out,
  output logic [31:0] ins_pc,
  input  logic        ins_ready,
  output logic        fault,
  output logic [31:0] fault_pc
);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [1:0]  count;
  logic [31:0] b0_dat, b0_pc, b1_dat, b1_pc;
  logic        legal, push, pop, fault_set;

  assign imem_addr = fetch_pc;
  assign ins_valid = (count != 2'd0);
  assign ins_out   = b0_dat;
  assign ins_pc    = b0_pc;
  assign fault     = (state == FAULT);

  // Range check is done in 33 bits so a PC near the top of the address space cannot wrap into range.
  always_comb begin
    legal        = (fetch_pc[1:0] == 2'b00) &&
                   (({1'b0, fetch_pc} + 33'd4) <= 33'(IMEM_BYTES));
    pop          = ins_valid && ins_ready;
    push         = 1'b0;
    fault_set    = 1'b0;
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    if (redirect_valid) begin
      state_nxt    = RUN;
      fetch_pc_nxt = redirect_pc;
    end else if (state == RUN && !halt) begin
      if (!legal) begin
        state_nxt = FAULT;
        fault_set = 1'b1;
      end else if (count != 2'd2 || pop) begin
        push         = 1'b1;
        fetch_pc_nxt = fetch_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      fault_pc <= 32'h0;
      count    <= 2'd0;
      b0_dat   <= 32'h0;
      b0_pc    <= 32'h0;
      b1_dat   <= 32'h0;
      b1_pc    <= 32'h0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (redirect_valid) begin
        fault_pc <= 32'h0;
      end else if (fault_set) begin
        fault_pc <= fetch_pc;
      end
      // A redirect flushes everything, including a pop presented in the same cycle.
      if (redirect_valid) begin
        count <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              b0_dat <= imem_data;
              b0_pc  <= fetch_pc;
            end else begin
              b1_dat <= imem_data;
              b1_pc  <= fetch_pc;
            end
            count <= count + 2'd1;
          end
          2'b01: begin
            b0_dat <= b1_dat;
            b0_pc  <= b1_pc;
            count  <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              b0_dat <= imem_data;
              b0_pc  <= fetch_pc;
            end else begin
              b0_dat <= b1_dat;
              b0_pc  <= b1_pc;
              b1_dat <= imem_data;
              b1_pc  <= fetch_pc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count == 2'd2) && !pop));

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: memory word at address a is 32'hC0DE_0000 ^ a.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic [31:0] ins_out;
  logic [31:0] ins_pc;
  logic        ins_ready;
  logic        fault;
  logic [31:0] fault_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_data = 32'hC0DE_0000 ^ imem_addr;

  ifetch_ctrl #(.RESET_PC(32'h0), .IMEM_BYTES(80)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_out        (ins_out),
    .ins_pc         (ins_pc),
    .ins_ready      (ins_ready),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'h0, ins_valid}, 32'd1);
    check({tag, "_pc"}, ins_pc, pc);
    check({tag, "_out"}, ins_out, 32'hC0DE_0000 ^ pc);
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'h0, ins_valid}, 32'd0);
    check({tag, "_out"}, ins_out, 32'h0);
    check({tag, "_pc"}, ins_pc, 32'h0);
    check({tag, "_fault"}, {31'h0, fault}, 32'd0);
    check({tag, "_fault_pc"}, fault_pc, 32'h0);
    check({tag, "_addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; ins_ready = 1'b1;
    step();
    expect_reset_outputs("reset");
    rst = 1'b0;

    // Streaming to the end of memory with no bubbles
    for (int k = 0; k < 20; k++) begin
      step();
      expect_head($sformatf("stream%0d", k), 32'(4 * k));
      check($sformatf("stream_addr%0d", k), imem_addr, 32'(4 * k + 4));
    end
    step();
    check("eom_fault", {31'h0, fault}, 32'd1);
    check("eom_fault_pc", fault_pc, 32'd80);
    check("eom_valid", {31'h0, ins_valid}, 32'd0);
    step();
    step();
    check("eom_hold_valid", {31'h0, ins_valid}, 32'd0);
    check("eom_hold_addr", imem_addr, 32'd80);
    check("eom_hold_fault", {31'h0, fault}, 32'd1);

    redirect_valid = 1'b1; redirect_pc = 32'd0;
    step();
    check("clr_fault", {31'h0, fault}, 32'd0);
    check("clr_fault_pc", fault_pc, 32'h0);
    check("clr_valid", {31'h0, ins_valid}, 32'd0);
    check("clr_addr", imem_addr, 32'd0);
    redirect_valid = 1'b0;
    step();
    expect_head("clr_head", 32'd0);

    // Backpressure from reset
    rst = 1'b1; ins_ready = 1'b0;
    step();
    rst = 1'b0;
    check("bp_empty", {31'h0, ins_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_head($sformatf("bp_hold%0d", i), 32'd0);
      check($sformatf("bp_addr%0d", i), imem_addr, (i == 0) ? 32'd4 : 32'd8);
    end
    ins_ready = 1'b1;
    step();
    expect_head("bp_rel", 32'd4);
    check("bp_rel_addr", imem_addr, 32'd12);

    // Redirect while holding pc 4,8; pop this cycle is discarded
    ins_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd16;
    step();
    check("rd_valid", {31'h0, ins_valid}, 32'd0);
    check("rd_addr", imem_addr, 32'd16);
    redirect_valid = 1'b0; ins_ready = 1'b1;
    step();
    expect_head("rd_h16", 32'd16);
    step();
    expect_head("rd_h20", 32'd20);

    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'd6;
    step();
    check("mis_valid0", {31'h0, ins_valid}, 32'd0);
    check("mis_fault0", {31'h0, fault}, 32'd0);
    check("mis_addr", imem_addr, 32'd6);
    redirect_valid = 1'b0;
    step();
    check("mis_fault", {31'h0, fault}, 32'd1);
    check("mis_fault_pc", fault_pc, 32'd6);
    check("mis_valid1", {31'h0, ins_valid}, 32'd0);
    step();
    check("mis_valid2", {31'h0, ins_valid}, 32'd0);
    check("mis_frozen", imem_addr, 32'd6);

    // Halt freezes fetch while the buffer drains
    redirect_valid = 1'b1; redirect_pc = 32'd0;
    step();
    redirect_valid = 1'b0;
    step();
    expect_head("ht_h0", 32'd0);
    ins_ready = 1'b0;
    step();
    expect_head("ht_full", 32'd0);
    check("ht_full_addr", imem_addr, 32'd8);
    halt = 1'b1; ins_ready = 1'b1;
    step();
    expect_head("ht_drain", 32'd4);
    check("ht_addr1", imem_addr, 32'd8);
    step();
    check("ht_empty1", {31'h0, ins_valid}, 32'd0);
    check("ht_addr2", imem_addr, 32'd8);
    step();
    check("ht_empty2", {31'h0, ins_valid}, 32'd0);
    check("ht_addr3", imem_addr, 32'd8);
    check("ht_nofault", {31'h0, fault}, 32'd0);
    halt = 1'b0;
    step();
    expect_head("ht_resume8", 32'd8);
    step();
    expect_head("ht_resume12", 32'd12);

    // Reset mid-stream
    rst = 1'b1;
    step();
    expect_reset_outputs("midrst");
    rst = 1'b0;
    step();
    expect_head("midrst_h0", 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer for the combinational byte-addressed instruction memory. It owns the fetch PC and drives the memory address. It captures each returned 32-bit word with its PC in a 2-entry skid buffer and presents them to decode over a valid/ready handshake. It handles branch/jump redirects, halt, and misaligned or out-of-range fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
IMEM_BYTES, 80, instruction memory size in bytes; a fetch is legal only if pc+4 <= IMEM_BYTES

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_addr  output  32  byte address to instruction memory; equals fetch_pc combinationally
imem_data  input  32  instruction word from memory, valid in the same cycle as imem_addr
halt  input  1  when 1, no new fetches; buffer still drains
redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc
redirect_pc  input  32  new fetch PC
ins_valid  output  1  buffer head holds an instruction
ins_out  output  32  head instruction word
ins_pc  output  32  PC of head instruction
ins_ready  input  1  decode accepts head this cycle
fault  output  1  fetch fault latched; fetching stopped
fault_pc  output  32  PC that caused the fault

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC, buffer empty, state RUN. Outputs: ins_valid=0, ins_out=0, ins_pc=0, fault=0, fault_pc=0. Reset overrides all other inputs.
- State RUN, fetch_pc legal means fetch_pc[1:0]==0 and fetch_pc+4 <= IMEM_BYTES, computed in 33 bits with no wrap.
- Push condition: RUN && !halt && !redirect_valid && legal && (count<2 || pop). A push writes {fetch_pc, imem_data} at the tail and sets fetch_pc += 4 in the same edge.
- Pop = ins_valid && ins_ready. The head advances, and a push and pop in the same cycle leave count unchanged.
- Latency: a word addressed in cycle N is visible at the head in cycle N+1 if the buffer was empty. Sustained throughput is 1 instr/cycle with ins_ready held at 1.
- Buffer outputs (ins_out, ins_pc) are registered and hold stable while ins_valid=1 && ins_ready=0. They must not change until popped.
- Illegal fetch: RUN && !halt && !redirect_valid && !legal → state FAULT, fault=1, fault_pc=fetch_pc, no push. Entries already in the buffer continue to drain normally.
- FAULT: no fetches, and fetch_pc is frozen. Only redirect or reset leave FAULT.
- Redirect (redirect_valid=1, either state): the buffer is flushed (count=0, so ins_valid=0 next cycle) and any pop that cycle is discarded. fetch_pc=redirect_pc, state=RUN, fault=0, fault_pc=0, and there is no push that cycle. Legality of redirect_pc is checked on the next cycle's fetch attempt; an illegal target faults one cycle later.
- Redirect has priority over push, pop and fault entry in the same cycle.
- halt=1 in RUN: no push, fetch_pc held, no fault check. Deasserting halt resumes at the held fetch_pc.
- Count is 2 bits (0..2). A push while count==2 without a pop is impossible by construction; an assertion must flag it.

Test Plan:
- Reset, ins_ready=1, memory holds words W0..W4 at 0,4,8,12,16 → ins_valid rises cycle 1 with ins_pc=0, ins_out=W0. Consecutive cycles then deliver pc 4,8,12,16 with no bubbles.
- Backpressure: ins_ready=0 for 5 cycles after reset → buffer fills with pc 0,4, and imem_addr holds at 8. ins_out=W0 stays stable. On ins_ready=1, pcs 0,4,8 emerge in order, none lost or duplicated.
- Redirect: while the buffer holds pc 4,8, pulse redirect_valid with redirect_pc=16 → ins_valid=0 the next cycle, then ins_pc=16, then 20.
- End of memory (IMEM_BYTES=80): run sequentially → pc 76 delivered, then fault=1 and fault_pc=80 with no further ins_valid. Redirect to 0 clears fault, and pc 0 follows.
- Misaligned redirect to 6 → fault=1, fault_pc=6 the cycle after the fetch attempt, and ins_valid stays 0. halt=1 for 3 cycles mid-stream freezes imem_addr, and the buffer drains. Assert rst mid-stream → all outputs return to reset values next cycle and fetch restarts at RESET_PC.
